vga_timing: RTL and testbench
=============================

Name: vga_timing

Overview:
- Raster timing generator and output stage for the 640x480@60 Hz display path.
- Upstream role: drives the pixel coordinates x/y consumed by the pong graphic stage.
- Downstream role: takes that stage's registered 8-bit rgb, blanks it outside the active area, and re-aligns it with hsync/vsync for the DAC/connector pins.
- Owns the pixel-clock enable, so the graphic stage sees one coordinate per pixel period.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch; H_TOTAL = 800
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch; V_TOTAL = 525
- CLK_DIV, 2, clk cycles per pixel (>=1)
- SYNC_POL, 0, active level of hsync/vsync (0 = active-low)
- PIPE_DLY, 1, clk cycles between x/y presenting a pixel and rgb_in carrying that pixel's colour (>=1)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- rgb_in  in  8  colour from graphic stage, bits [B1 B2 G1 G2 G3 R1 R2 R3]
- x  out  11  current horizontal pixel, 0..H_TOTAL-1
- y  out  11  current line, 0..V_TOTAL-1
- pix_en  out  1  one-clk strobe, last clk of each pixel period
- frame_start  out  1  one-clk pulse, first clk of pixel (0,0)
- hsync  out  1  horizontal sync to pins
- vsync  out  1  vertical sync to pins
- video_on  out  1  high while rgb_out carries an active-area pixel
- rgb_out  out  8  colour to pins, 8'h00 when blanked

Behaviour:
- Reset is synchronous and active-high on clk; there is no asynchronous path. At the first edge with reset high:
  - div_cnt=0, x=0, y=0, pix_en=0, frame_start=0
  - hsync=vsync=~SYNC_POL, video_on=0, rgb_out=8'h00
  - delay line cleared to inactive
- Divider: div_cnt counts 0..CLK_DIV-1 and wraps. pix_en = (div_cnt==CLK_DIV-1), combinational from the register. With CLK_DIV=1, pix_en is held high.
- Counters (registered, advance only on pix_en):
  - x==H_TOTAL-1 -> x=0, and y advances.
  - y==V_TOTAL-1 at end of line -> y=0.
  - x and y each hold steady for exactly CLK_DIV clks.
- frame_start = (x==0 && y==0 && div_cnt==0); exactly one clk per frame, including with CLK_DIV=1.
- Raw control, decoded combinationally from x/y:
  - h_act = x < H_ACTIVE
  - v_act = y < V_ACTIVE
  - hs_raw = H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC (656..751)
  - vs_raw = V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC (490..491)
  - act = h_act && v_act
- Alignment: {act, hs_raw, vs_raw} pass through a PIPE_DLY-stage register delay line, then into the output register.
  - At each edge: video_on<=act_d; hsync<=hs_d ? SYNC_POL : ~SYNC_POL; vsync likewise; rgb_out<=act_d ? rgb_in : 8'h00.
  - Net latency: the pixel first shown on x/y at edge e0 appears on all pin outputs after edge e0+PIPE_DLY+1.
  - Outputs are sampled every clk, not gated by pix_en, so each pixel persists CLK_DIV clks on the pins.
- Arithmetic: all comparisons are unsigned 11-bit; boundary sums are compile-time constants. A parameter set with H_TOTAL or V_TOTAL > 2047 is illegal and fails elaboration.
- Boundaries:
  - Line and frame wrap in the same pixel tick: x=0 and y=0 together, no intermediate (0,525) state.
  - Reset mid-frame: the next clk returns everything to reset values; stale pixels in the delay line never reach the pins.
  - rgb_in during blanking is ignored.

Decomposition:
- Package vga_pkg holds:
  - timing localparams and H_TOTAL/V_TOTAL derivation
  - COORD_W=11, RGB_W=8
  - COLOR_NULL=8'h00
  - sync polarity constants
- Sub-module vga_delay_line: parameterised width/depth shift register with synchronous clear, used for the control delay.

Test Plan:
1. Reset held 3 clks, then released -> x=0, y=0, hsync=vsync=1, rgb_out=00; first pix_en on 2nd clk after release (CLK_DIV=2).
2. Free-run one line -> 800 pix_en between x wraps; hsync low for 192 clks, starting PIPE_DLY+1=2 clks after x first shows 656.
3. Free-run two frames -> vsync low exactly 1600 pixel periods (y=490..491); frame_start pulses once every 840000 clks.
4. rgb_in held 8'hFF -> rgb_out=FF and video_on=1 only for x<640, y<480; rgb_out=00 for x 640..799 and lines 480..524; edges 2 clks after x/y.
5. Bench model of graphic: rgb_in = x[7:0] registered 1 clk -> when video_on, rgb_out equals the x value shown 2 clks earlier (e.g. 8'd100 for pixel 100), never off by one pixel.
6. Assert reset for 1 clk at x=300, y=200 mid-active -> next clk x=0, y=0, video_on=0, rgb_out=00; no pixel-300 colour emitted afterwards; normal timing resumes.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants, types and helpers for the 640x480 raster path.
// Defaults describe 640x480@60 Hz; totals derive from the four spans.
package vga_pkg;

    localparam int COORD_W = 11;
    localparam int RGB_W   = 8;
    localparam int COORD_MAX = (1 << COORD_W) - 1;

    localparam logic [RGB_W-1:0] COLOR_NULL = 8'h00;

    localparam logic SYNC_ACT_LOW  = 1'b0;
    localparam logic SYNC_ACT_HIGH = 1'b1;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;

    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    // Control bits that travel alongside a pixel through the delay line.
    typedef struct packed {
        logic act;
        logic hs;
        logic vs;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    function automatic int span_total(
        input int active,
        input int fp,
        input int sync,
        input int bp
    );
        return active + fp + sync + bp;
    endfunction

    function automatic logic in_span(
        input logic [COORD_W-1:0] v,
        input logic [COORD_W-1:0] lo,
        input logic [COORD_W-1:0] hi
    );
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth register delay with synchronous clear.
// Clearing empties every stage so stale entries never emerge.
module vga_delay_line #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_d
);

    logic [WIDTH-1:0] r_sh [DEPTH];

    always_ff @(posedge clk) begin
        if (i_clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_sh[i] <= '0;
            end
        end else begin
            r_sh[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) begin
                r_sh[i] <= r_sh[i-1];
            end
        end
    end

    assign o_d = r_sh[DEPTH-1];

endmodule

// File: rtl/vga_timing.sv
// Raster counters, sync decode and blanking output stage.
// Pins carry the pixel shown on x/y PIPE_DLY+1 clocks earlier.
module vga_timing
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = H_ACTIVE_DEF,
    parameter int   H_FP     = H_FP_DEF,
    parameter int   H_SYNC   = H_SYNC_DEF,
    parameter int   H_BP     = H_BP_DEF,
    parameter int   V_ACTIVE = V_ACTIVE_DEF,
    parameter int   V_FP     = V_FP_DEF,
    parameter int   V_SYNC   = V_SYNC_DEF,
    parameter int   V_BP     = V_BP_DEF,
    parameter int   CLK_DIV  = 2,
    parameter logic SYNC_POL = SYNC_ACT_LOW,
    parameter int   PIPE_DLY = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [RGB_W-1:0]   rgb_in,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               pix_en,
    output logic               frame_start,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic [RGB_W-1:0]   rgb_out
);

    localparam int H_TOTAL =
        span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL =
        span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [COORD_W-1:0] H_ACT  =
        COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] HS_BEG =
        COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_END =
        COORD_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] H_LAST =
        COORD_W'(H_TOTAL - 1);

    localparam logic [COORD_W-1:0] V_ACT  =
        COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] VS_BEG =
        COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_END =
        COORD_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [COORD_W-1:0] V_LAST =
        COORD_W'(V_TOTAL - 1);

    localparam int DIV_W =
        (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST =
        DIV_W'(CLK_DIV - 1);

    if (H_TOTAL > COORD_MAX || V_TOTAL > COORD_MAX) begin : g_bad_total
        $error("vga_timing: line/frame total exceeds coordinate range");
    end

    if (CLK_DIV < 1 || PIPE_DLY < 1) begin : g_bad_div
        $error("vga_timing: CLK_DIV and PIPE_DLY must be at least 1");
    end

    logic [DIV_W-1:0]   r_div;
    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;

    logic               w_div_last;
    logic               w_h_end;
    logic               w_v_end;
    ctrl_t              w_ctrl;
    ctrl_t              w_ctrl_d;

    logic               r_video_on;
    logic               r_hsync;
    logic               r_vsync;
    logic [RGB_W-1:0]   r_rgb;

    assign w_div_last = (r_div == DIV_LAST);
    assign w_h_end    = (r_x == H_LAST);
    assign w_v_end    = (r_y == V_LAST);

    always_ff @(posedge clk) begin
        if (reset || w_div_last) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // Line and frame wrap share one tick, so (0,V_TOTAL) never appears.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_div_last) begin
            if (w_h_end) begin
                r_x <= '0;
                r_y <= w_v_end ? '0 : r_y + 1'b1;
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end

    assign x = r_x;
    assign y = r_y;

    // Strobes stay quiet while reset is held, even with CLK_DIV=1.
    assign pix_en      = w_div_last && !reset;
    assign frame_start = (r_x == '0) && (r_y == '0)
                      && (r_div == '0) && !reset;

    always_comb begin
        w_ctrl     = '0;
        w_ctrl.act = (r_x < H_ACT) && (r_y < V_ACT);
        w_ctrl.hs  = in_span(r_x, HS_BEG, HS_END);
        w_ctrl.vs  = in_span(r_y, VS_BEG, VS_END);
    end

    vga_delay_line #(
        .WIDTH (CTRL_W),
        .DEPTH (PIPE_DLY)
    ) u_ctrl_dly (
        .clk   (clk),
        .i_clr (reset),
        .i_d   (w_ctrl),
        .o_d   (w_ctrl_d)
    );

    // Sampled every clk so each pixel lasts CLK_DIV clks on the pins.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_video_on <= 1'b0;
            r_hsync    <= ~SYNC_POL;
            r_vsync    <= ~SYNC_POL;
            r_rgb      <= COLOR_NULL;
        end else begin
            r_video_on <= w_ctrl_d.act;
            r_hsync    <= w_ctrl_d.hs ? SYNC_POL : ~SYNC_POL;
            r_vsync    <= w_ctrl_d.vs ? SYNC_POL : ~SYNC_POL;
            r_rgb      <= w_ctrl_d.act ? rgb_in : COLOR_NULL;
        end
    end

    assign video_on = r_video_on;
    assign hsync    = r_hsync;
    assign vsync    = r_vsync;
    assign rgb_out  = r_rgb;

endmodule

// File: tb/tb_vga_timing.sv
// Three raster configurations checked against a clock-count model.
// Pixel colours come from a keyed function of the model's coordinates.
module tb_vga_timing;
    import vga_pkg::*;

    localparam int N = 3;

    localparam int P_HA [N]  = '{16, 640, 20};
    localparam int P_HF [N]  = '{4, 16, 3};
    localparam int P_HS [N]  = '{6, 96, 5};
    localparam int P_HB [N]  = '{4, 48, 2};
    localparam int P_VA [N]  = '{10, 480, 6};
    localparam int P_VF [N]  = '{2, 10, 1};
    localparam int P_VS [N]  = '{2, 2, 2};
    localparam int P_VB [N]  = '{3, 33, 2};
    localparam int P_DIV[N]  = '{2, 2, 1};
    localparam int P_DLY[N]  = '{1, 1, 3};
    localparam int P_POL[N]  = '{0, 0, int'(SYNC_ACT_HIGH)};

    typedef struct {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               pe;
        logic               fs;
        logic               hs;
        logic               vs;
        logic               von;
        logic [RGB_W-1:0]   rgb;
    } exp_t;

    logic               clk;
    logic               reset;
    logic [RGB_W-1:0]   rgb_in  [N];
    logic [COORD_W-1:0] x_o     [N];
    logic [COORD_W-1:0] y_o     [N];
    logic               pe_o    [N];
    logic               fs_o    [N];
    logic               hs_o    [N];
    logic               vs_o    [N];
    logic               von_o   [N];
    logic [RGB_W-1:0]   rgb_o   [N];

    int  checks;
    int  failures;
    int  tcur;
    bit  valid;
    bit  rekey;
    int  key_k [N];
    int  key_s [N];
    bit  key_ff[N];
    int  pend_k [N];
    int  pend_s [N];
    bit  pend_ff[N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        vga_timing #(
            .H_ACTIVE (P_HA[g]),
            .H_FP     (P_HF[g]),
            .H_SYNC   (P_HS[g]),
            .H_BP     (P_HB[g]),
            .V_ACTIVE (P_VA[g]),
            .V_FP     (P_VF[g]),
            .V_SYNC   (P_VS[g]),
            .V_BP     (P_VB[g]),
            .CLK_DIV  (P_DIV[g]),
            .SYNC_POL (P_POL[g] != 0),
            .PIPE_DLY (P_DLY[g])
        ) dut (
            .clk         (clk),
            .reset       (reset),
            .rgb_in      (rgb_in[g]),
            .x           (x_o[g]),
            .y           (y_o[g]),
            .pix_en      (pe_o[g]),
            .frame_start (fs_o[g]),
            .hsync       (hs_o[g]),
            .vsync       (vs_o[g]),
            .video_on    (von_o[g]),
            .rgb_out     (rgb_o[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int htot(input int i);
        return P_HA[i] + P_HF[i] + P_HS[i] + P_HB[i];
    endfunction

    function automatic int vtot(input int i);
        return P_VA[i] + P_VF[i] + P_VS[i] + P_VB[i];
    endfunction

    // Pixel shown during clock n after the last reset edge.
    function automatic void pix_at(
        input int i, input int n, output int px, output int py
    );
        int p;
        p  = n / P_DIV[i];
        px = p % htot(i);
        py = (p / htot(i)) % vtot(i);
    endfunction

    function automatic logic [RGB_W-1:0] color(
        input int i, input int px, input int py
    );
        if (key_ff[i]) return 8'hFF;
        return 8'(px + py * key_k[i] + key_s[i]);
    endfunction

    function automatic exp_t model(input int i, input int n, input bit rn);
        exp_t e;
        int px, py, qx, qy;
        logic pol, act, hsa, vsa;
        pol = (P_POL[i] != 0);
        pix_at(i, n, px, py);
        e.x  = 11'(px);
        e.y  = 11'(py);
        e.pe = !rn && ((n % P_DIV[i]) == P_DIV[i] - 1);
        e.fs = !rn && ((n % (P_DIV[i] * htot(i) * vtot(i))) == 0);
        e.von = 1'b0;
        e.rgb = 8'h00;
        e.hs  = ~pol;
        e.vs  = ~pol;
        if (n >= P_DLY[i] + 1) begin
            pix_at(i, n - P_DLY[i] - 1, qx, qy);
            act = (qx < P_HA[i]) && (qy < P_VA[i]);
            hsa = (qx >= P_HA[i] + P_HF[i])
               && (qx < P_HA[i] + P_HF[i] + P_HS[i]);
            vsa = (qy >= P_VA[i] + P_VF[i])
               && (qy < P_VA[i] + P_VF[i] + P_VS[i]);
            e.von = act;
            e.rgb = act ? color(i, qx, qy) : 8'h00;
            e.hs  = hsa ? pol : ~pol;
            e.vs  = vsa ? pol : ~pol;
        end
        return e;
    endfunction

    task automatic chk(
        input string tag, input int i,
        input logic [31:0] obs, input logic [31:0] expv
    );
        checks++;
        assert (obs === expv) else begin
            failures++;
            $display("FAIL %s[%0d] t=%0d got=%0h exp=%0h",
                     tag, i, tcur, obs, expv);
            $error("%s[%0d] got %0h expected %0h", tag, i, obs, expv);
        end
    endtask

    task automatic check_all(input bit rn);
        exp_t e;
        for (int i = 0; i < N; i++) begin
            e = model(i, tcur, rn);
            chk("x", i, 32'(x_o[i]), 32'(e.x));
            chk("y", i, 32'(y_o[i]), 32'(e.y));
            chk("pix_en", i, 32'(pe_o[i]), 32'(e.pe));
            chk("frame_start", i, 32'(fs_o[i]), 32'(e.fs));
            chk("hsync", i, 32'(hs_o[i]), 32'(e.hs));
            chk("vsync", i, 32'(vs_o[i]), 32'(e.vs));
            chk("video_on", i, 32'(von_o[i]), 32'(e.von));
            chk("rgb_out", i, 32'(rgb_o[i]), 32'(e.rgb));
        end
    endtask

    // One clock: drive reset/rgb for this period, then check outputs.
    task automatic step(input bit rst);
        bit rst_q;
        int px, py;
        @(posedge clk);
        rst_q = reset;
        #1;
        if (rst_q) begin
            tcur  = 0;
            valid = 1'b1;
        end else if (valid) begin
            tcur++;
        end
        reset = rst;
        for (int i = 0; i < N; i++) begin
            if (valid && tcur >= P_DLY[i]) begin
                pix_at(i, tcur - P_DLY[i], px, py);
                rgb_in[i] = color(i, px, py);
            end else begin
                rgb_in[i] = 8'($urandom);
            end
        end
        #1;
        if (valid) check_all(rst);
        if (rekey && rst) begin
            for (int i = 0; i < N; i++) begin
                key_k[i]  = pend_k[i];
                key_s[i]  = pend_s[i];
                key_ff[i] = pend_ff[i];
            end
            rekey = 1'b0;
        end
    endtask

    task automatic new_keys(input bit ff);
        for (int i = 0; i < N; i++) begin
            pend_k[i]  = int'($urandom_range(1, 255));
            pend_s[i]  = int'($urandom_range(0, 255));
            pend_ff[i] = ff;
        end
        rekey = 1'b1;
    endtask

    initial begin
        int n;
        int px, py;
        bit hit;
        checks   = 0;
        failures = 0;
        tcur     = 0;
        valid    = 1'b0;
        rekey    = 1'b0;
        reset    = 1'b1;
        for (int i = 0; i < N; i++) begin
            rgb_in[i] = 8'h00;
            key_k[i]  = 0;
            key_s[i]  = 0;
            key_ff[i] = 1'b0;
        end

        repeat (3) step(1'b1);
        repeat (3000) step(1'b0);

        new_keys(1'b0);
        repeat ($urandom_range(200, 900)) step(1'b0);
        step(1'b1);
        repeat (2500) step(1'b0);

        for (int k = 0; k < 4; k++) begin
            new_keys(1'b0);
            repeat ($urandom_range(50, 600)) step(1'b0);
            n = int'($urandom_range(1, 3));
            repeat (n) step(1'b1);
        end
        repeat (800) step(1'b0);

        hit = 1'b0;
        for (int k = 0; k < 2000 && !hit; k++) begin
            step(1'b0);
            pix_at(0, tcur, px, py);
            hit = (px >= 5) && (px < 12) && (py >= 3) && (py < 7);
        end
        step(1'b1);
        repeat (600) step(1'b0);

        new_keys(1'b1);
        step(1'b1);
        repeat (1200) step(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
